// File: rtl/led_bank_ctrl_pkg.sv
// Shared definitions for the LED bank controller: channel mode encodings and width helpers.
package led_bank_ctrl_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_BLINK = 2'd2,
        LED_PWM   = 2'd3
    } led_mode_e;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_prescaler.sv
// Free-running divider producing a single-cycle tick every TICK_DIV clocks.
module led_prescaler #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/led_bank_ctrl.sv
// Per-channel LED mode controller (off/on/blink/PWM) with registered active-low outputs.
module led_bank_ctrl
    import led_bank_ctrl_pkg::*;
#(
    parameter int NUM_LEDS    = 4,
    parameter int TICK_DIV    = 50000,
    parameter int PWM_BITS    = 8,
    parameter int BLINK_TICKS = 250,
    localparam int CH_W       = idx_w(NUM_LEDS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [MODE_W-1:0]   wr_mode,
    input  logic [PWM_BITS-1:0] wr_duty,
    output logic                tick,
    output logic [NUM_LEDS-1:0] led_n
);

    localparam int BW = idx_w(BLINK_TICKS);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

    logic                               tick_i;
    logic                               wr_ok;
    logic [NUM_LEDS-1:0][MODE_W-1:0]    mode_q;
    logic [NUM_LEDS-1:0][PWM_BITS-1:0]  duty_q;
    logic [PWM_BITS-1:0]                pwm_cnt;
    logic [BW-1:0]                      blink_cnt;
    logic                               blink_ph;
    logic [NUM_LEDS-1:0]                lit;

    led_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick_i)
    );

    assign tick  = tick_i;
    // Only matters for non-power-of-two builds where the index can exceed the bank.
    assign wr_ok = wr_en && (int'(wr_ch) < NUM_LEDS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= '0;
            duty_q <= '0;
        end else if (wr_ok) begin
            mode_q[wr_ch] <= wr_mode;
            duty_q[wr_ch] <= wr_duty;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pwm_cnt <= '0;
        else if (tick_i)
            pwm_cnt <= pwm_cnt + 1'b1;
    end

    // Single phase shared by every channel keeps all blinking LEDs in step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else if (tick_i) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                blink_ph  <= ~blink_ph;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
        always_comb begin
            lit[i] = 1'b0;
            case (led_mode_e'(mode_q[i]))
                LED_OFF:   lit[i] = 1'b0;
                LED_ON:    lit[i] = 1'b1;
                LED_BLINK: lit[i] = blink_ph;
                LED_PWM:   lit[i] = (pwm_cnt < duty_q[i]);
                default:   lit[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            led_n <= '1;
        else
            led_n <= ~lit;
    end

endmodule

// File: tb/tb_led_bank_ctrl.sv
// Scoreboard bench for led_bank_ctrl: a 4-channel build plus a 3-channel build for the dropped-write case.
module tb_led_bank_ctrl;
    import led_bank_ctrl_pkg::*;

    localparam int TD = 4;
    localparam int PB = 3;
    localparam int BT = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0, wr_en3 = 1'b0;
    logic [1:0] wr_ch = '0, wr_ch3 = '0;
    logic [1:0] wr_mode = '0, wr_mode3 = '0;
    logic [2:0] wr_duty = '0, wr_duty3 = '0;
    logic       tick, tick3;
    logic [3:0] led_n;
    logic [2:0] led_n3;

    always #5 clk = ~clk;

    led_bank_ctrl #(.NUM_LEDS(4), .TICK_DIV(TD), .PWM_BITS(PB), .BLINK_TICKS(BT)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_mode(wr_mode),
        .wr_duty(wr_duty), .tick(tick), .led_n(led_n)
    );

    led_bank_ctrl #(.NUM_LEDS(3), .TICK_DIV(TD), .PWM_BITS(PB), .BLINK_TICKS(BT)) dut3 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en3), .wr_ch(wr_ch3), .wr_mode(wr_mode3),
        .wr_duty(wr_duty3), .tick(tick3), .led_n(led_n3)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: counter state derived from edges since reset release.
    int n = 0;
    int m4[4], d4[4], m3[3], d3[3];
    logic [3:0] q4[$];
    logic [2:0] q3[$];
    bit         qt[$];

    function automatic bit lit(input int mode, input int duty, input int k);
        int t;
        t = k / TD;
        case (mode)
            1:       return 1'b1;
            2:       return ((t / BT) % 2) == 1;
            3:       return (t % (1 << PB)) < duty;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        n = 0;
        foreach (m4[i]) begin m4[i] = 0; d4[i] = 0; end
        foreach (m3[i]) begin m3[i] = 0; d3[i] = 0; end
    endtask

    task automatic cyc();
        logic [3:0] e4;
        logic [2:0] e3;
        for (int i = 0; i < 4; i++) e4[i] = ~lit(m4[i], d4[i], n);
        for (int i = 0; i < 3; i++) e3[i] = ~lit(m3[i], d3[i], n);
        q4.push_back(e4);
        q3.push_back(e3);
        qt.push_back(((n + 1) % TD) == TD - 1);
        @(posedge clk);
        n++;
        if (wr_en) begin m4[wr_ch] = int'(wr_mode); d4[wr_ch] = int'(wr_duty); end
        if (wr_en3 && wr_ch3 < 3) begin m3[wr_ch3] = int'(wr_mode3); d3[wr_ch3] = int'(wr_duty3); end
        #1;
        chk("led_n", 32'(led_n), 32'(q4.pop_front()));
        chk("led_n3", 32'(led_n3), 32'(q3.pop_front()));
        begin
            bit et;
            et = qt.pop_front();
            chk("tick", 32'(tick), 32'(et));
            chk("tick3", 32'(tick3), 32'(et));
        end
    endtask

    task automatic wr(input int ch, input led_mode_e mode, input int duty);
        wr_en = 1'b1; wr_ch = 2'(ch); wr_mode = mode; wr_duty = 3'(duty);
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic wr3(input int ch, input led_mode_e mode, input int duty);
        wr_en3 = 1'b1; wr_ch3 = 2'(ch); wr_mode3 = mode; wr_duty3 = 3'(duty);
        cyc();
        wr_en3 = 1'b0;
    endtask

    task automatic pwm_lows(input string tag, input int exp);
        int lows;
        lows = 0;
        repeat (32) begin
            cyc();
            if (!led_n[2]) lows++;
        end
        chk(tag, 32'(lows), 32'(exp));
    endtask

    initial begin
        model_reset();
        #12;
        chk("rst_led_n", 32'(led_n), 32'hF);
        chk("rst_tick", 32'(tick), 32'h0);
        chk("rst_led_n3", 32'(led_n3), 32'h7);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        // Tick cadence after release.
        repeat (12) cyc();

        // ON / OFF with one-cycle latency.
        wr(1, LED_ON, 0);
        cyc();
        chk("on_led", 32'(led_n), 32'hD);
        repeat (4) cyc();
        wr(1, LED_OFF, 0);
        cyc();
        chk("off_led", 32'(led_n), 32'hF);

        // Blink, then a repeated BLINK write that must not disturb the phase.
        wr(0, LED_BLINK, 0);
        repeat (29) cyc();
        wr(0, LED_BLINK, 5);
        repeat (24) cyc();
        wr(0, LED_OFF, 0);

        // PWM duty sweep, including both extremes.
        wr(2, LED_PWM, 3);
        repeat (8) cyc();
        pwm_lows("pwm_duty3_lows", 12);
        wr(2, LED_PWM, 0);
        repeat (4) cyc();
        pwm_lows("pwm_duty0_lows", 0);
        wr(2, LED_PWM, 7);
        repeat (4) cyc();
        pwm_lows("pwm_duty7_lows", 28);

        // Out-of-range channel on the 3-channel build is dropped.
        wr3(1, LED_ON, 0);
        cyc();
        chk("n3_on", 32'(led_n3), 32'h5);
        wr3(3, LED_ON, 0);
        repeat (3) cyc();
        chk("n3_oor", 32'(led_n3), 32'h5);
        wr3(3, LED_OFF, 0);
        cyc();
        chk("n3_oor_off", 32'(led_n3), 32'h5);

        // All channels lit, then an asynchronous reset mid-cycle.
        wr(0, LED_ON, 0);
        wr(1, LED_ON, 0);
        wr(3, LED_ON, 0);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                cyc();
                if (led_n == 4'h0) seen = 1'b1;
            end
            chk("all_lit_seen", 32'(seen), 32'h1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_led_n", 32'(led_n), 32'hF);
        chk("async_rst_led_n3", 32'(led_n3), 32'h7);
        chk("async_rst_tick", 32'(tick), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (9) cyc();
        wr(2, LED_PWM, 7);
        repeat (40) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
